// File: rtl/grid_io_pkg.sv
// Shared types and constants for the parametrised IO grid tile.
package grid_io_pkg;

  localparam int IO_CFG_W        = 3;
  localparam int IO_CFG_OE_BIT   = 0;
  localparam int IO_CFG_IE_BIT   = 1;
  localparam int IO_CFG_INV_BIT  = 2;

  // Per-pad configuration word as held in the shadow register.
  typedef struct packed {
    logic inv;
    logic ie;
    logic oe;
  } io_cfg_t;

  // Unpack a raw chain slice into named fields via the bit-position constants.
  function automatic io_cfg_t io_cfg_unpack(input logic [IO_CFG_W-1:0] bits);
    io_cfg_t c;
    c.oe  = bits[IO_CFG_OE_BIT];
    c.ie  = bits[IO_CFG_IE_BIT];
    c.inv = bits[IO_CFG_INV_BIT];
    return c;
  endfunction

endpackage

// File: rtl/grid_io_pad_cell.sv
// Per-pad combinational datapath driven by one committed config word.
module grid_io_pad_cell
  import grid_io_pkg::*;
(
  input  io_cfg_t cfg,
  input  logic    pin_outpad,
  input  logic    gpio_y,
  output logic    gpio_oe,
  output logic    gpio_a,
  output logic    pin_inpad
);

  // Output path inverts on request; input path is gated to 0 when disabled.
  always_comb begin
    gpio_oe   = cfg.oe;
    gpio_a    = pin_outpad ^ cfg.inv;
    pin_inpad = cfg.ie ? (gpio_y ^ cfg.inv) : 1'b0;
  end

endmodule

// File: rtl/grid_io_param.sv
// Parametrised IO grid tile: gated serial config chain, shadow config
// committed on cfg_done rising edge, and a chain-length check at commit.
module grid_io_param
  import grid_io_pkg::*;
#(
  parameter int N_PADS = 8,
  // Pad cells decode a fixed io_cfg_t, so only IO_CFG_W is meaningful here.
  parameter int CFG_W  = IO_CFG_W
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              cfg_done,
  input  logic              ccff_shift_en,
  input  logic              ccff_head,
  output logic              ccff_tail,
  input  logic [N_PADS-1:0] pin_outpad,
  output logic [N_PADS-1:0] pin_inpad,
  output logic [N_PADS-1:0] gpio_a,
  output logic [N_PADS-1:0] gpio_oe,
  input  logic [N_PADS-1:0] gpio_y,
  output logic              cfg_valid,
  output logic              cfg_len_err
);

  localparam int CHAIN_LEN = N_PADS * CFG_W;
  localparam int CNT_W     = $clog2(CHAIN_LEN + 2);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CHAIN_LEN + 1);

  logic [CHAIN_LEN-1:0] sr_q, sr_d;
  logic [CHAIN_LEN-1:0] sh_q, sh_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 cfg_done_q, cfg_done_d;
  logic                 cfg_valid_q, cfg_valid_d;
  logic                 cfg_len_err_q, cfg_len_err_d;
  logic                 commit;

  // Next-state for chain, counter and commit. Commit uses the pre-shift
  // chain contents and wins over a concurrent shift for the counter.
  always_comb begin
    commit        = cfg_done & ~cfg_done_q;
    sr_d          = sr_q;
    sh_d          = sh_q;
    cnt_d         = cnt_q;
    cfg_done_d    = cfg_done;
    cfg_valid_d   = cfg_valid_q;
    cfg_len_err_d = cfg_len_err_q;

    if (ccff_shift_en) begin
      sr_d = {sr_q[CHAIN_LEN-2:0], ccff_head};
    end

    if (commit) begin
      sh_d          = sr_q;
      cfg_valid_d   = 1'b1;
      cfg_len_err_d = (cnt_q != CNT_FULL);
      cnt_d         = '0;
    end else if (ccff_shift_en && (cnt_q != CNT_SAT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers; reset drops every pad to tri-state immediately.
  always_ff @(posedge prog_clk or negedge prog_reset) begin
    if (!prog_reset) begin
      sr_q          <= '0;
      sh_q          <= '0;
      cnt_q         <= '0;
      cfg_done_q    <= 1'b0;
      cfg_valid_q   <= 1'b0;
      cfg_len_err_q <= 1'b0;
    end else begin
      sr_q          <= sr_d;
      sh_q          <= sh_d;
      cnt_q         <= cnt_d;
      cfg_done_q    <= cfg_done_d;
      cfg_valid_q   <= cfg_valid_d;
      cfg_len_err_q <= cfg_len_err_d;
    end
  end

  assign ccff_tail   = sr_q[CHAIN_LEN-1];
  assign cfg_valid   = cfg_valid_q;
  assign cfg_len_err = cfg_len_err_q;

  for (genvar i = 0; i < N_PADS; i++) begin : g_pad
    grid_io_pad_cell u_pad (
      .cfg        (io_cfg_unpack(sh_q[i*CFG_W +: IO_CFG_W])),
      .pin_outpad (pin_outpad[i]),
      .gpio_y     (gpio_y[i]),
      .gpio_oe    (gpio_oe[i]),
      .gpio_a     (gpio_a[i]),
      .pin_inpad  (pin_inpad[i])
    );
  end

endmodule

// File: tb/tb_grid_io_param.sv
// Directed bench for grid_io_param with N_PADS=8 (24-bit chain).
module tb_grid_io_param;
  import grid_io_pkg::*;

  localparam int N = 8;
  localparam logic [2:0] M_OE  = 3'(1 << IO_CFG_OE_BIT);
  localparam logic [2:0] M_IE  = 3'(1 << IO_CFG_IE_BIT);
  localparam logic [2:0] M_INV = 3'(1 << IO_CFG_INV_BIT);

  logic         prog_clk = 1'b0;
  logic         prog_reset;
  logic         cfg_done;
  logic         ccff_shift_en;
  logic         ccff_head;
  logic         ccff_tail;
  logic [N-1:0] pin_outpad;
  logic [N-1:0] pin_inpad;
  logic [N-1:0] gpio_a;
  logic [N-1:0] gpio_oe;
  logic [N-1:0] gpio_y;
  logic         cfg_valid;
  logic         cfg_len_err;

  int checks = 0;
  int errors = 0;

  grid_io_param #(.N_PADS(N), .CFG_W(3)) dut (
    .prog_clk      (prog_clk),
    .prog_reset    (prog_reset),
    .cfg_done      (cfg_done),
    .ccff_shift_en (ccff_shift_en),
    .ccff_head     (ccff_head),
    .ccff_tail     (ccff_tail),
    .pin_outpad    (pin_outpad),
    .pin_inpad     (pin_inpad),
    .gpio_a        (gpio_a),
    .gpio_oe       (gpio_oe),
    .gpio_y        (gpio_y),
    .cfg_valid     (cfg_valid),
    .cfg_len_err   (cfg_len_err)
  );

  always #5 prog_clk = ~prog_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge prog_clk);
    #1;
  endtask

  // Shift n bits of w, MSB (bit n-1) first, so w[k] ends up in chain bit k.
  task automatic shift_bits(input logic [63:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      ccff_head     = w[i];
      ccff_shift_en = 1'b1;
      tick();
    end
    ccff_shift_en = 1'b0;
    ccff_head     = 1'b0;
  endtask

  task automatic commit();
    cfg_done = 1'b1;
    tick();
  endtask

  task automatic drop_done();
    cfg_done = 1'b0;
    tick();
  endtask

  logic [23:0] p_nom, p_inv, p_gl, p_rb;
  int          idx;
  logic        exp_bit;

  initial begin
    for (int i = 0; i < N; i++) begin
      p_nom[i*3 +: 3] = M_OE | M_IE;
      p_inv[i*3 +: 3] = (i == 3) ? (M_INV | M_OE) : (M_OE | M_IE);
      p_gl[i*3 +: 3]  = (i % 2 == 0) ? (M_OE | M_IE) : M_IE;
    end
    p_rb = 24'hA5A5A5;

    prog_reset    = 1'b0;
    cfg_done      = 1'b0;
    ccff_shift_en = 1'b0;
    ccff_head     = 1'b0;
    pin_outpad    = '0;
    gpio_y        = '0;
    #1;
    chk("rst_oe",    gpio_oe,     8'h00);
    chk("rst_inpad", pin_inpad,   8'h00);
    chk("rst_tail",  ccff_tail,   1'b0);
    chk("rst_valid", cfg_valid,   1'b0);
    chk("rst_err",   cfg_len_err, 1'b0);
    tick();
    prog_reset = 1'b1;
    tick();

    // Nominal load: nothing visible until commit.
    shift_bits({40'd0, p_nom}, 24);
    chk("pre_commit_oe",    gpio_oe,   8'h00);
    chk("pre_commit_valid", cfg_valid, 1'b0);
    commit();
    chk("nom_valid", cfg_valid,   1'b1);
    chk("nom_err",   cfg_len_err, 1'b0);
    chk("nom_oe",    gpio_oe,     8'hFF);
    pin_outpad = 8'h3C; gpio_y = 8'h96; #1;
    chk("nom_a0",     gpio_a,    8'h3C);
    chk("nom_inpad0", pin_inpad, 8'h96);
    pin_outpad = 8'hC5; gpio_y = 8'h5A; #1;
    chk("nom_a1",     gpio_a,    8'hC5);
    chk("nom_inpad1", pin_inpad, 8'h5A);

    // Reprogramming does not disturb the pads until the next rising edge.
    drop_done();
    for (int i = 23; i >= 0; i--) begin
      ccff_head     = p_gl[i];
      ccff_shift_en = 1'b1;
      tick();
      chk("noglitch_oe", gpio_oe, 8'hFF);
    end
    ccff_shift_en = 1'b0;
    commit();
    chk("gl_oe", gpio_oe, 8'h55);
    // Held high with chain activity: a second commit would change gpio_oe.
    shift_bits(64'd0, 10);
    chk("hold_oe",    gpio_oe,   8'h55);
    chk("hold_valid", cfg_valid, 1'b1);

    // Length errors (23, 25, and a long run that must saturate).
    drop_done();
    shift_bits({40'd0, p_nom}, 23);
    commit();
    chk("len23_err",   cfg_len_err, 1'b1);
    chk("len23_valid", cfg_valid,   1'b1);
    drop_done();
    chk("err_sticky", cfg_len_err, 1'b1);
    shift_bits({40'd0, p_nom}, 25);
    commit();
    chk("len25_err", cfg_len_err, 1'b1);
    drop_done();
    shift_bits(64'd0, 56);
    commit();
    chk("len56_err", cfg_len_err, 1'b1);

    // Correct reload clears the error; pad 3 inverted with input disabled.
    drop_done();
    shift_bits({40'd0, p_inv}, 24);
    commit();
    chk("len24_err", cfg_len_err, 1'b0);
    chk("inv_oe",    gpio_oe,     8'hFF);
    pin_outpad = 8'hFF; gpio_y = 8'hFF; #1;
    chk("inv_a_ff",     gpio_a,    8'hF7);
    chk("inv_inpad_ff", pin_inpad, 8'hF7);
    pin_outpad = 8'h08; gpio_y = 8'h08; #1;
    chk("inv_a_08",     gpio_a,    8'h00);
    chk("inv_inpad_08", pin_inpad, 8'h00);

    // Shift during the commit cycle: pre-shift value committed, shift uncounted.
    drop_done();
    shift_bits({40'd0, p_nom}, 24);
    cfg_done      = 1'b1;
    ccff_shift_en = 1'b1;
    ccff_head     = 1'b1;
    tick();
    ccff_shift_en = 1'b0;
    ccff_head     = 1'b0;
    chk("sc_oe",  gpio_oe,     8'hFF);
    chk("sc_err", cfg_len_err, 1'b0);
    drop_done();
    shift_bits({40'd0, p_gl}, 24);
    commit();
    chk("sc_cnt_err", cfg_len_err, 1'b0);
    chk("sc_gl_oe",   gpio_oe,     8'h55);

    // Asynchronous reset mid-operation.
    gpio_y   = 8'hFF;
    cfg_done = 1'b0;
    tick();
    #2 prog_reset = 1'b0;
    #1;
    chk("arst_oe",    gpio_oe,     8'h00);
    chk("arst_inpad", pin_inpad,   8'h00);
    chk("arst_valid", cfg_valid,   1'b0);
    prog_reset = 1'b1;
    tick();
    shift_bits(64'hFFFFFF, 24);
    chk("ones_tail", ccff_tail, 1'b1);
    ccff_shift_en = 1'b1;
    ccff_head     = 1'b1;
    tick();
    #2 prog_reset = 1'b0;
    #1;
    chk("arst_shift_tail", ccff_tail, 1'b0);
    chk("arst_shift_err",  cfg_len_err, 1'b0);
    ccff_shift_en = 1'b0;
    ccff_head     = 1'b0;
    prog_reset    = 1'b1;
    tick();
    chk("no_partial_valid", cfg_valid, 1'b0);
    chk("no_partial_oe",    gpio_oe,   8'h00);

    // Readback: head-to-tail latency is exactly 24 shifts, then MSB-first.
    shift_bits({41'd0, p_rb[23:1]}, 23);
    chk("rb_tail_23", ccff_tail, 1'b0);
    shift_bits({63'd0, p_rb[0]}, 1);
    chk("rb_tail_24", ccff_tail, p_rb[23]);
    idx = 23;
    for (int c = 0; c < 48; c++) begin
      exp_bit = (idx >= 0) ? p_rb[idx] : 1'b0;
      chk("rb_tail", ccff_tail, exp_bit);
      ccff_head     = 1'b0;
      ccff_shift_en = (c % 2 == 0);
      tick();
      if (c % 2 == 0) idx--;
    end
    ccff_shift_en = 1'b0;
    chk("rb_tail_end", ccff_tail, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/grid_io_param.md
Name: grid_io_param

Overview:
- Parametrised successor of the fixed 8-subtile IO grid tile.
- Holds N_PADS pad subtiles, each with CFG_W configuration bits on one serial configuration chain (ccff_head -> ccff_tail).
- Adds three things the fixed tile lacks:
  - shift-enable gating of the chain;
  - a shadow (active) config register committed on the cfg_done rising edge, so pad modes never glitch during reprogramming;
  - a shifted-bit counter that flags a wrong chain length at commit.
- Sits at the fabric edge, between the routing channel pins and the top-level GPIO pads.

Parameters:
- N_PADS, 8, number of IO subtiles (1..64).
- CFG_W, 3, config bits per pad: bit0 OE enable, bit1 IE enable, bit2 invert.
- CHAIN_LEN, N_PADS*CFG_W, derived; total chain length (localparam).

Ports:
- prog_clk  in  1  configuration clock; the only clock.
- prog_reset  in  1  asynchronous, active-low reset.
- cfg_done  in  1  configuration complete; rising edge commits the shift register to the shadow register.
- ccff_shift_en  in  1  shift chain by one bit when high.
- ccff_head  in  1  serial config data in.
- ccff_tail  out  1  serial config data out (last shift-register bit).
- pin_outpad  in  N_PADS  fabric-to-pad data, bit i = subtile i.
- pin_inpad  out  N_PADS  pad-to-fabric data.
- gpio_a  out  N_PADS  pad output data.
- gpio_oe  out  N_PADS  pad output enable, active high.
- gpio_y  in  N_PADS  pad input data.
- cfg_valid  out  1  shadow register holds a committed configuration.
- cfg_len_err  out  1  last commit saw a shifted-bit count different from CHAIN_LEN.

Behaviour:
- Reset (prog_reset=0, async) clears:
  - shift register (SR), shadow register (SH), bit counter, cfg_done_q;
  - cfg_valid=0, cfg_len_err=0, ccff_tail=0.
- Consequences of SH=0: gpio_oe=0 and pin_inpad=0 on all pads; pads are tri-stated.
- Shift:
  - On prog_clk rising edge with ccff_shift_en=1, SR shifts by one bit.
  - ccff_head enters pad 0 bit 0; pad p bit b feeds pad p bit b+1; bit CFG_W-1 feeds pad p+1 bit 0.
  - Pad N_PADS-1 bit CFG_W-1 drives ccff_tail, registered: one-cycle delay per stage, CHAIN_LEN cycles head-to-tail.
  - ccff_shift_en=0: SR holds.
- Bit counter:
  - Increments on every shift; saturates at CHAIN_LEN+1.
  - Width $clog2(CHAIN_LEN+2).
- Commit:
  - cfg_done_q registers cfg_done; commit fires when cfg_done=1 and cfg_done_q=0.
  - Commit cycle actions:
    - SH <= SR;
    - cfg_valid <= 1;
    - cfg_len_err <= (count != CHAIN_LEN);
    - counter <= 0.
  - Shift and commit in the same cycle: SH takes the pre-shift SR value; the counter clears (the concurrent shift is not counted).
  - cfg_done held high: no further commits.
  - cfg_done falling: SH retained, pads keep operating; new shifting allowed, takes effect at the next rising edge.
  - cfg_len_err is sticky until the next commit or reset. It is informational only; the commit still happens.
- Datapath, combinational from SH, zero latency:
  - gpio_oe[i] = SH[i].oe;
  - gpio_a[i] = pin_outpad[i] ^ SH[i].inv;
  - pin_inpad[i] = SH[i].ie ? (gpio_y[i] ^ SH[i].inv) : 0.
- Reset mid-shift or mid-commit: everything returns to reset values immediately; a partial configuration is never committed.

Decomposition:
- Package grid_io_pkg:
  - typedef io_cfg_t, a packed struct {inv, ie, oe} (CFG_W=3);
  - constants IO_CFG_OE_BIT=0, IO_CFG_IE_BIT=1, IO_CFG_INV_BIT=2.
- One natural sub-module: grid_io_pad_cell, the per-pad combinational datapath (SH slice -> gpio_oe/gpio_a/pin_inpad), generated N_PADS times.
- Chain, counter and commit logic stay in the top.

Test Plan:
- Reset state: assert prog_reset=0 mid-operation.
  -> gpio_oe=0, pin_inpad=0, ccff_tail=0, cfg_valid=0 at once, without waiting for a clock edge.
- Nominal load, N_PADS=8: shift 24 bits so every pad gets oe=1, ie=1, inv=0; raise cfg_done.
  -> cfg_valid=1, cfg_len_err=0, gpio_oe=8'hFF, gpio_a follows pin_outpad, pin_inpad follows gpio_y.
- Invert and input-disable: pad 3 {inv=1, ie=0, oe=1}, drive pin_outpad[3]=1 and gpio_y[3]=1.
  -> gpio_a[3]=0, pin_inpad[3]=0.
- Length error: shift 23 bits then commit -> cfg_len_err=1. Repeat with 25 bits -> cfg_len_err=1. Reload 24 bits and recommit -> cfg_len_err=0.
- No glitch during reconfiguration:
  - Drop cfg_done and shift a new pattern: gpio_oe unchanged for all 24 cycles.
  - Raise cfg_done: new pattern visible in the cycle after the edge.
  - Hold cfg_done high for 10 cycles: no second commit.
- Readback: shift in 24'hA5A5A5 then 24 more zeros with shift_en toggled 50%.
  -> ccff_tail emits A5A5A5 MSB-first, stalling whenever shift_en=0.
